// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command master: state encoding, response sizes,
// setting-word field offsets and error-flag bit positions.
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ACK,
    ST_FINAL,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [1:0] RSP_NONE  = 2'b00;
  localparam logic [1:0] RSP_SHORT = 2'b01;
  localparam logic [1:0] RSP_LONG  = 2'b10;

  localparam logic [6:0] RSP_SIZE_NONE  = 7'd0;
  localparam logic [6:0] RSP_SIZE_SHORT = 7'd40;
  localparam logic [6:0] RSP_SIZE_LONG  = 7'd127;

  localparam int SET_SIZE_LSB = 0;
  localparam int SET_CRC_BIT  = 7;
  localparam int SET_DLY_LSB  = 8;
  localparam int SET_WR_BIT   = 11;
  localparam int SET_RD_BIT   = 12;
  localparam int SET_WSEL_LSB = 13;

  localparam int ERR_TIMEOUT = 3;
  localparam int ERR_CRC     = 2;
  localparam int ERR_INDEX   = 1;
  localparam int ERR_ABORT   = 0;

  localparam int STAT_CRC_OK_BIT = 5;
  localparam int STAT_FINAL_BIT  = 6;

  // The reserved encoding behaves exactly like a short response.
  function automatic logic [1:0] rsp_norm(input logic [1:0] t);
    return (t == 2'b11) ? RSP_SHORT : t;
  endfunction

  function automatic logic [6:0] rsp_size(input logic [1:0] t);
    case (rsp_norm(t))
      RSP_NONE: return RSP_SIZE_NONE;
      RSP_LONG: return RSP_SIZE_LONG;
      default:  return RSP_SIZE_SHORT;
    endcase
  endfunction

endpackage

// File: rtl/sd_cmd_timeout.sv
// Loadable down-counter watchdog; expire is high while enabled and the count has run out.
module sd_cmd_timeout #(
  parameter int W = 16
) (
  input  logic         SD_CLK_IN,
  input  logic         RST_IN,
  input  logic         load,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expire = en & (count == '0);

endmodule

// File: rtl/sd_cmd_master.sv
// Command-issue sequencer: latches a host command, runs REQ/ACK and STATUS handshakes
// with the serial host, checks the response and reports done/error flags.
module sd_cmd_master
  import sd_cmd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd4095,
  parameter logic [2:0]  DLY_CYC = 3'd7
) (
  input  logic        SD_CLK_IN,
  input  logic        RST_IN,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] arg_i,
  input  logic [1:0]  rsp_type_i,
  input  logic        crc_chk_i,
  input  logic        idx_chk_i,
  input  logic        blk_rd_i,
  input  logic        blk_wr_i,
  input  logic [1:0]  word_sel_i,
  output logic        req_o,
  input  logic        ready_i,
  output logic [39:0] cmd_o,
  output logic [15:0] setting_o,
  input  logic        status_req_i,
  input  logic [15:0] status_i,
  input  logic [39:0] rsp_i,
  output logic        ack_o,
  output logic        go_idle_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] resp_o,
  output logic [5:0]  resp_idx_o,
  output logic [3:0]  err_o
);

  state_t      state, state_nxt;
  logic        accept, capture, check, abort_hit, tout_hit, ack_nxt;
  logic        tout_en, tout_expire;
  logic [1:0]  rtype;
  logic        crc_chk, idx_chk;
  logic        stat_final, stat_crc_ok;
  logic [15:0] setting_nxt;
  logic        unused_bits;

  assign unused_bits = ^{status_i[15:7], status_i[4:0], rsp_i[39:38]};

  always_comb begin
    setting_nxt = '0;
    setting_nxt[SET_SIZE_LSB +: 7] = rsp_size(rsp_type_i);
    setting_nxt[SET_CRC_BIT]       = crc_chk_i;
    setting_nxt[SET_DLY_LSB +: 3]  = DLY_CYC;
    setting_nxt[SET_WR_BIT]        = blk_wr_i;
    setting_nxt[SET_RD_BIT]        = blk_rd_i;
    setting_nxt[SET_WSEL_LSB +: 2] = word_sel_i;
  end

  assign tout_en = state inside {ST_REQ, ST_WAIT, ST_ACK, ST_FINAL};

  sd_cmd_timeout #(.W(16)) u_timeout (
    .SD_CLK_IN (SD_CLK_IN),
    .RST_IN    (RST_IN),
    .load      (accept),
    .clear     ((state == ST_IDLE) && !accept),
    .en        (tout_en),
    .load_val  (TIMEOUT - 16'd1),
    .expire    (tout_expire)
  );

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    check     = 1'b0;
    abort_hit = 1'b0;
    tout_hit  = 1'b0;
    ack_nxt   = ack_o;
    case (state)
      ST_IDLE: if (start_i && ready_i) begin
        accept    = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ: if (!ready_i) state_nxt = ST_WAIT;
      ST_WAIT: if (status_req_i && !ack_o) begin
        capture   = 1'b1;
        ack_nxt   = 1'b1;
        state_nxt = ST_ACK;
      end
      ST_ACK: if (!status_req_i) begin
        ack_nxt   = 1'b0;
        state_nxt = stat_final ? ST_FINAL : ST_WAIT;
      end
      // Ack is re-raised in FINAL so the serial host can leave its post-read delay.
      ST_FINAL: begin
        ack_nxt = !ready_i;
        if (ready_i) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        check     = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Abort outranks the watchdog; an abort in DONE must not repeat the done pulse.
    if ((state != ST_IDLE) && abort_i) begin
      abort_hit = 1'b1;
      capture   = 1'b0;
      check     = 1'b0;
      ack_nxt   = 1'b0;
      state_nxt = (state == ST_DONE) ? ST_IDLE : ST_DONE;
    end else if (tout_expire) begin
      tout_hit  = 1'b1;
      capture   = 1'b0;
      ack_nxt   = 1'b0;
      state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      cmd_o       <= '0;
      setting_o   <= '0;
      rtype       <= RSP_NONE;
      crc_chk     <= 1'b0;
      idx_chk     <= 1'b0;
      stat_final  <= 1'b0;
      stat_crc_ok <= 1'b0;
      ack_o       <= 1'b0;
      go_idle_o   <= 1'b0;
      resp_o      <= '0;
      resp_idx_o  <= '0;
      err_o       <= '0;
    end else begin
      ack_o     <= ack_nxt;
      go_idle_o <= abort_hit | tout_hit;
      if (accept) begin
        cmd_o       <= {2'b01, cmd_index_i, arg_i};
        setting_o   <= setting_nxt;
        rtype       <= rsp_norm(rsp_type_i);
        crc_chk     <= crc_chk_i;
        idx_chk     <= idx_chk_i;
        stat_final  <= 1'b0;
        stat_crc_ok <= 1'b0;
        err_o       <= '0;
      end
      if (capture) begin
        stat_final  <= status_i[STAT_FINAL_BIT];
        stat_crc_ok <= status_i[STAT_CRC_OK_BIT];
      end
      if (check) begin
        resp_o            <= rsp_i[31:0];
        resp_idx_o        <= rsp_i[37:32];
        err_o[ERR_CRC]    <= crc_chk && !stat_crc_ok && (rtype != RSP_NONE);
        err_o[ERR_INDEX]  <= idx_chk && (rtype == RSP_SHORT) && (rsp_i[37:32] != cmd_o[37:32]);
      end
      if (abort_hit) err_o[ERR_ABORT]   <= 1'b1;
      if (tout_hit)  err_o[ERR_TIMEOUT] <= 1'b1;
    end
  end

  assign req_o  = (state == ST_REQ);
  assign busy_o = (state != ST_IDLE);
  assign done_o = (state == ST_DONE);

endmodule

// File: tb/tb_sd_cmd_master.sv
// Bench for sd_cmd_master: the bench plays the serial host and predicts every output
// from the command fields and the status/response words it hands back.
module tb_sd_cmd_master;

  localparam logic [15:0] TO = 16'd64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, abort_i, crc_chk_i, idx_chk_i, blk_rd_i, blk_wr_i;
  logic [5:0]  cmd_index_i;
  logic [31:0] arg_i;
  logic [1:0]  rsp_type_i, word_sel_i;
  logic        req_o, ready_i, status_req_i, ack_o, go_idle_o, busy_o, done_o;
  logic [39:0] cmd_o, rsp_i;
  logic [15:0] setting_o, status_i;
  logic [31:0] resp_o;
  logic [5:0]  resp_idx_o;
  logic [3:0]  err_o;

  always #5 clk = ~clk;

  sd_cmd_master #(.TIMEOUT(TO), .DLY_CYC(3'd7)) dut (
    .SD_CLK_IN(clk), .RST_IN(rst), .start_i(start_i), .abort_i(abort_i),
    .cmd_index_i(cmd_index_i), .arg_i(arg_i), .rsp_type_i(rsp_type_i),
    .crc_chk_i(crc_chk_i), .idx_chk_i(idx_chk_i), .blk_rd_i(blk_rd_i), .blk_wr_i(blk_wr_i),
    .word_sel_i(word_sel_i), .req_o(req_o), .ready_i(ready_i), .cmd_o(cmd_o),
    .setting_o(setting_o), .status_req_i(status_req_i), .status_i(status_i), .rsp_i(rsp_i),
    .ack_o(ack_o), .go_idle_o(go_idle_o), .busy_o(busy_o), .done_o(done_o),
    .resp_o(resp_o), .resp_idx_o(resp_idx_o), .err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req"}, req_o, 0);
    chk({tag, ".ack"}, ack_o, 0);
    chk({tag, ".go_idle"}, go_idle_o, 0);
    chk({tag, ".busy"}, busy_o, 0);
    chk({tag, ".done"}, done_o, 0);
    chk({tag, ".cmd"}, cmd_o, 0);
    chk({tag, ".setting"}, setting_o, 0);
    chk({tag, ".resp"}, resp_o, 0);
    chk({tag, ".resp_idx"}, resp_idx_o, 0);
    chk({tag, ".err"}, err_o, 0);
  endtask

  // Issues a command and accepts it; leaves the DUT in WAIT with ready_i low.
  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                       input logic cc, input logic ic, input logic rd, input logic wr,
                       input logic [1:0] ws, output int t0);
    logic [39:0] exp_cmd;
    logic [15:0] exp_set;
    logic [6:0]  sz;
    logic [1:0]  norm;
    norm    = (rt == 2'b11) ? 2'b01 : rt;
    sz      = (norm == 2'b00) ? 7'd0 : (norm == 2'b01) ? 7'd40 : 7'd127;
    exp_cmd = {2'b01, idx, arg};
    exp_set = {1'b0, ws, rd, wr, 3'd7, cc, sz};
    ready_i = 1'b1; status_req_i = 1'b0;
    cmd_index_i = idx; arg_i = arg; rsp_type_i = rt; crc_chk_i = cc; idx_chk_i = ic;
    blk_rd_i = rd; blk_wr_i = wr; word_sel_i = ws; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    t0 = cyc;
    chk("start.busy", busy_o, 1);
    chk("start.req", req_o, 1);
    chk("start.cmd", cmd_o, exp_cmd);
    chk("start.setting", setting_o, exp_set);
    chk("start.err_clr", err_o, 0);
    // A second request while busy (and with the serial host idle) must be ignored.
    cmd_index_i = ~idx; arg_i = ~arg; rsp_type_i = ~rt; crc_chk_i = ~cc; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      chk("req.hold", req_o, 1);
      tick;
    end
    ready_i = 1'b0;
    tick;
    chk("req.fall", req_o, 0);
    chk("busy_start.cmd", cmd_o, exp_cmd);
    chk("busy_start.setting", setting_o, exp_set);
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic cc, input logic ic, input logic rd, input logic wr,
                         input logic [1:0] ws, input int mode, input int nint,
                         input logic [15:0] fstat, input logic [39:0] rsp);
    int t0;
    logic [15:0] st;
    logic [1:0]  norm;
    logic [3:0]  exp_err;
    norm = (rt == 2'b11) ? 2'b01 : rt;
    issue(idx, arg, rt, cc, ic, rd, wr, ws, t0);
    if (mode == 2) begin
      while (go_idle_o !== 1'b1 && (cyc - t0) < 300) tick;
      chk("tout.cycles", cyc - t0, TO);
      chk("tout.go_idle", go_idle_o, 1);
      chk("tout.done", done_o, 1);
      chk("tout.err", err_o, 4'b1000);
      chk("tout.req", req_o, 0);
      chk("tout.ack", ack_o, 0);
      ready_i = 1'b1;
      tick;
      chk("tout.go_idle_pulse", go_idle_o, 0);
      chk("tout.done_pulse", done_o, 0);
      chk("tout.idle", busy_o, 0);
    end else if (mode == 1) begin
      repeat ($urandom_range(0, 2)) tick;
      chk("abort.busy", busy_o, 1);
      abort_i = 1'b1;
      tick;
      abort_i = 1'b0;
      chk("abort.done", done_o, 1);
      chk("abort.go_idle", go_idle_o, 1);
      chk("abort.err", err_o, 4'b0001);
      ready_i = 1'b1;
      tick;
      chk("abort.idle", busy_o, 0);
      chk("abort.done_pulse", done_o, 0);
    end else begin
      for (int i = 0; i <= nint; i++) begin
        st = (i == nint) ? (fstat | 16'h0040) : (16'($urandom) & 16'hffbf);
        repeat ($urandom_range(0, 2)) tick;
        chk("stat.ack_idle", ack_o, 0);
        status_req_i = 1'b1;
        status_i     = st;
        tick;
        chk("stat.ack_rise", ack_o, 1);
        repeat ($urandom_range(0, 1)) begin
          tick;
          chk("stat.ack_hold", ack_o, 1);
        end
        status_req_i = 1'b0;
        status_i     = 16'($urandom) & 16'hff9f;
        tick;
        chk("stat.ack_fall", ack_o, 0);
      end
      tick;
      chk("final.ack", ack_o, 1);
      rsp_i   = rsp;
      ready_i = 1'b1;
      tick;
      chk("check.ack", ack_o, 0);
      chk("check.done", done_o, 0);
      tick;
      exp_err = {1'b0, cc && !fstat[5] && norm != 2'b00,
                 ic && norm == 2'b01 && rsp[37:32] != idx, 1'b0};
      chk("done.pulse", done_o, 1);
      chk("done.resp", resp_o, rsp[31:0]);
      chk("done.resp_idx", resp_idx_o, rsp[37:32]);
      chk("done.err", err_o, exp_err);
      chk("done.go_idle", go_idle_o, 0);
      tick;
      chk("idle.done", done_o, 0);
      chk("idle.busy", busy_o, 0);
      chk("idle.err_hold", err_o, exp_err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; start_i = 0; abort_i = 0; cmd_index_i = 0; arg_i = 0; rsp_type_i = 0;
    crc_chk_i = 0; idx_chk_i = 0; blk_rd_i = 0; blk_wr_i = 0; word_sel_i = 0;
    ready_i = 1; status_req_i = 0; status_i = 0; rsp_i = 0;
    #2;
    chk_zero("reset");
    tick; tick;
    rst = 1'b0;
    tick;
    chk_zero("post_reset");

    // CMD0, no response
    run_cmd(6'd0, 32'h0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 16'h0040, 40'h12_3456_789A);
    chk("cmd0.setting", setting_o, 16'h0700);
    chk("cmd0.cmd", cmd_o, 40'h40_0000_0000);
    // CMD17 good, then bad index and CRC
    run_cmd(6'd17, 32'h200, 2'b01, 1, 1, 1, 0, 2'b00, 0, 1, 16'h0060, {2'b00, 6'd17, 32'hCAFE_F00D});
    run_cmd(6'd17, 32'h200, 2'b01, 1, 1, 1, 0, 2'b00, 0, 0, 16'h0040, {2'b00, 6'd3, 32'h0BAD_0BAD});
    chk("cmd17_bad.err", err_o, 4'b0110);
    run_cmd(6'd8, 32'h1AA, 2'b01, 1, 1, 0, 0, 2'b00, 2, 0, 16'h0, 40'h0);
    run_cmd(6'd55, 32'h0, 2'b01, 1, 1, 0, 0, 2'b00, 1, 0, 16'h0, 40'h0);

    // Reset while in ACK
    issue(6'd13, 32'hDEAD_BEEF, 2'b01, 1, 1, 0, 0, 2'b00, t0);
    status_req_i = 1'b1; status_i = 16'h0060;
    tick;
    chk("rst_ack.ack", ack_o, 1);
    #2 rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    tick;
    chk("rst_mid.no_done", done_o, 0);
    status_req_i = 1'b0; ready_i = 1'b1; rst = 1'b0;
    tick;
    run_cmd(6'd9, 32'h5555_0000, 2'b10, 1, 0, 0, 1, 2'b11, 0, 2, 16'h0060, 40'h3F_1234_5678);

    for (int n = 0; n < 40; n++) begin
      int r, mode;
      logic [5:0] idx;
      logic [39:0] rsp;
      r    = $urandom_range(0, 9);
      mode = (r == 0) ? 2 : (r < 3) ? 1 : 0;
      idx  = 6'($urandom);
      rsp  = {2'($urandom), ($urandom_range(0, 1) == 1) ? idx : 6'($urandom), $urandom};
      run_cmd(idx, $urandom, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 2'($urandom), mode, $urandom_range(0, 2), 16'($urandom), rsp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_cmd_master.md
# sd_cmd_master

Command-issue sequencer between the host-side command registers and the SD command serial host. Takes a host start request (index, argument, response type, check flags), forms the 40-bit command word and 16-bit setting word, and runs the REQ/ACK handshakes with the serial host. It then collects the intermediate and final STATUS words, latches the response, checks CRC and index, applies a watchdog timeout, and reports done and error flags to the interrupt and register logic.

## Interface
- `TIMEOUT`, 16'd4095: SD_CLK_IN cycles allowed from `req_o` rise to final status before abort.
- `DLY_CYC`, 3'd7: no-response turnaround cycles, placed in `setting_o[10:8]`.
- `SD_CLK_IN` in 1: clock; every flop is on its rising edge.
- `RST_IN` in 1: reset, asynchronous, active-high.
- `start_i` in 1: one-cycle command request; ignored while `busy_o`=1.
- `abort_i` in 1: one-cycle software abort.
- `cmd_index_i` in 6: command index.
- `arg_i` in 32: command argument.
- `rsp_type_i` in 2: 00 none, 01 short (48-bit), 10 long (136-bit), 11 reserved (treated as 01).
- `crc_chk_i`, `idx_chk_i` in 1 each: enable the response CRC check and the index check.
- `blk_rd_i`, `blk_wr_i` in 1 each: data-phase hints, passed through into the setting word.
- `word_sel_i` in 2: which 32-bit word of a long response to capture.
- `req_o` out 1: command request to the serial host (its REQ_IN).
- `ready_i` in 1: serial host ACK_OUT; 1 = idle/accepting.
- `cmd_o` out 40: command word to the serial host (its CMD_IN).
- `setting_o` out 16: setting word to the serial host (its SETTING_IN).
- `status_req_i` in 1: serial host status strobe (its REQ_OUT).
- `status_i` in 16: serial host STATUS.
- `rsp_i` in 40: serial host CMD_OUT.
- `ack_o` out 1: status acknowledge (its ACK_IN).
- `go_idle_o` out 1: one-cycle pulse to the serial host GO_IDLE.
- `busy_o` out 1: transaction in progress.
- `done_o` out 1: one-cycle completion pulse.
- `resp_o` out 32: captured response word.
- `resp_idx_o` out 6: response index field.
- `err_o` out 4: {timeout, crc, index, aborted}; holds until the next accepted start.

## Operation
- Reset values: all outputs 0 (including `cmd_o`, `setting_o`, `resp_o`, `err_o`); state IDLE; timeout counter 0.
- `cmd_o` = {2'b01, `cmd_index_i`, `arg_i`}, latched at start.
- `setting_o` fields:
  - [6:0] = 0 for type none, 40 for short, 127 for long.
  - [7] = `crc_chk_i`; [10:8] = `DLY_CYC`; [11] = `blk_wr_i`; [12] = `blk_rd_i`; [14:13] = `word_sel_i`; [15] = 0.
  - Latched at start and held stable until DONE.
- States:
  - IDLE: if `start_i` & `ready_i`, latch inputs, clear `err_o`, go REQ. `start_i` with `ready_i`=0 is dropped.
  - REQ: `req_o`=1; when `ready_i`=0 (serial host accepted), go WAIT.
  - WAIT: `req_o`=0. On `status_req_i`=1 with `ack_o`=0: capture `status_i`, set `ack_o`=1, go ACK.
  - ACK: when `status_req_i`=0, `ack_o`=0. If the captured status has bit6 set, go FINAL; otherwise go WAIT.
  - FINAL: `ack_o`=1 (lets the serial host leave its post-read delay); when `ready_i`=1, go CHECK.
  - CHECK: `ack_o`=0. Latch `resp_o` = `rsp_i[31:0]` and `resp_idx_o` = `rsp_i[37:32]`.
    - crc err = `crc_chk_i` & !status[5] & type≠none.
    - index err = `idx_chk_i` & type=short & `resp_idx_o`≠`cmd_index_i`.
    - Go DONE.
  - DONE: `done_o`=1 for one cycle; go IDLE.
- Timeout: the counter runs in REQ/WAIT/ACK/FINAL and clears in IDLE. At `TIMEOUT` it forces err[3], a one-cycle `go_idle_o`, `req_o`/`ack_o`=0, then DONE.
- Abort: `abort_i` in any state other than IDLE sets err[0], pulses `go_idle_o`, and goes to DONE. `abort_i` in IDLE has no effect.
- Abort and timeout in the same cycle: abort wins; only err[0] is set.
- `busy_o` = 1 in every state except IDLE.

## Timing
- `start_i` sampled at edge N: `busy_o` and `req_o` = 1 after edge N.
- `req_o` falls the cycle after `ready_i` is sampled low. Minimum high time is 3 cycles because the serial host double-flops REQ.
- `ack_o` rises one cycle after `status_req_i` is sampled high, and falls one cycle after it is sampled low. The 4-phase handshake never skips a phase.
- `done_o` comes 2 cycles after `ready_i` returns high in FINAL.
- `RST_IN` mid-transaction: all outputs 0 immediately; no `done_o` is produced.

## Structure
- Shared package `sd_cmd_pkg`: state encoding; response-size constants (0/40/127); `setting_o` field offsets; `err_o` bit positions.
- One natural sub-module: `sd_cmd_timeout`, a loadable down-counter with enable, clear and expire outputs.

## Test plan
- CMD0, type none, `ready_i` toggled by a serial-host model → `setting_o`=16'h0700, `cmd_o`=40'h4000000000, `done_o` pulses, `err_o`=0.
- CMD17, arg 0x00000200, short, crc+idx check; model returns status bit5=1, `rsp_i[37:32]`=17 → `resp_o`=`rsp_i[31:0]`, `err_o`=0.
- Same command with `rsp_i[37:32]`=3 and status bit5=0 → `err_o`=4'b0110.
- Model never raises `status_req_i`, `TIMEOUT`=16 → `go_idle_o` pulse 16 cycles after `req_o` rise, `err_o`=4'b1000, `done_o`.
- `abort_i` in WAIT, and separately `start_i` while busy → `err_o`=4'b0001; the second start is ignored (`cmd_o` unchanged).
- `RST_IN` asserted in ACK → all outputs 0 within the same cycle; a new start after release completes normally.
